// File: rtl/adder_seq_pkg.sv
// Shared types, widths and operand helpers for the five-adder operand sequencer.
package adder_seq_pkg;

  localparam int NUM_OPS = 4;
  localparam int OP_W    = 4;
  localparam int SUM_W   = 6;

  // Encoding is ordered so each timed state advances to state+1.
  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_SETUP0  = 4'd1,
    ST_HOLD0   = 4'd2,
    ST_SETUP1  = 4'd3,
    ST_HOLD1   = 4'd4,
    ST_SETUP2  = 4'd5,
    ST_HOLD2   = 4'd6,
    ST_SETUP3  = 4'd7,
    ST_HOLD3   = 4'd8,
    ST_ROT     = 4'd9,
    ST_RELEASE = 4'd10
  } seq_state_e;

  function automatic logic [OP_W-1:0] op_slice(input logic [NUM_OPS*OP_W-1:0] ops,
                                               input logic [1:0] idx);
    return ops[idx*OP_W +: OP_W];
  endfunction

  function automatic logic [SUM_W-1:0] nibble_sum(input logic [NUM_OPS*OP_W-1:0] ops);
    logic [SUM_W-1:0] acc;
    acc = {SUM_W{1'b0}};
    for (int i = 0; i < NUM_OPS; i++) begin
      acc = acc + SUM_W'(op_slice(ops, 2'(i)));
    end
    return acc;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter with a zero flag; times every non-idle sequencer state.
module phase_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Count down to zero and park there until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != {W{1'b0}}) begin
      count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/adder_operand_sequencer.sv
// Drives four operands into the front-panel adder via t/PB1..PB4, requests the sum
// with ROT_SWITCH, captures it and compares it with a locally computed sum.
module adder_operand_sequencer
  import adder_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int RESULT_WAIT   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [NUM_OPS*OP_W-1:0]  operands,
  output logic                     busy,
  output logic                     done,
  output logic [SUM_W-1:0]         result,
  output logic                     result_cout,
  output logic                     mismatch,
  output logic [OP_W-1:0]          t,
  output logic                     pb1,
  output logic                     pb2,
  output logic                     pb3,
  output logic                     pb4,
  output logic                     rot_switch,
  input  logic [SUM_W-1:0]         sum_in,
  input  logic                     cout_in
);

  localparam int TMR_W = 16;
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] ROT_LOAD    = TMR_W'(RESULT_WAIT - 1);

  seq_state_e                state_r, state_next_s;
  logic [NUM_OPS*OP_W-1:0]   ops_r, ops_src_s;
  logic [SUM_W-1:0]          expected_r;
  logic                      tmr_load_s, tmr_zero_s;
  logic [TMR_W-1:0]          tmr_val_s;
  logic [OP_W-1:0]           t_s;
  logic [3:0]                pb_s;
  logic                      rot_s, busy_s, done_s;

  phase_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .zero     (tmr_zero_s)
  );

  // Next-state logic: every timed state advances when its phase count expires.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_SETUP0;
        else       state_next_s = ST_IDLE;
      end
      ST_SETUP0, ST_HOLD0, ST_SETUP1, ST_HOLD1,
      ST_SETUP2, ST_HOLD2, ST_SETUP3, ST_HOLD3, ST_ROT: begin
        if (tmr_zero_s) state_next_s = seq_state_e'(state_r + 4'd1);
        else            state_next_s = state_r;
      end
      ST_RELEASE: begin
        if (tmr_zero_s) state_next_s = ST_IDLE;
        else            state_next_s = ST_RELEASE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output decode from the next state so every output is a plain register.
  always_comb begin
    tmr_load_s = (state_next_s != state_r);
    tmr_val_s  = (state_next_s == ST_ROT) ? ROT_LOAD : SETTLE_LOAD;
    ops_src_s  = (state_r == ST_IDLE) ? operands : ops_r;
    t_s        = {OP_W{1'b0}};
    pb_s       = 4'b0000;
    rot_s      = 1'b0;
    busy_s     = 1'b1;
    case (state_next_s)
      ST_IDLE:    busy_s = 1'b0;
      ST_SETUP0:  t_s = op_slice(ops_src_s, 2'd0);
      ST_HOLD0:   begin t_s = op_slice(ops_src_s, 2'd0); pb_s = 4'b0001; end
      ST_SETUP1:  begin t_s = op_slice(ops_src_s, 2'd1); pb_s = 4'b0001; end
      ST_HOLD1:   begin t_s = op_slice(ops_src_s, 2'd1); pb_s = 4'b0011; end
      ST_SETUP2:  begin t_s = op_slice(ops_src_s, 2'd2); pb_s = 4'b0011; end
      ST_HOLD2:   begin t_s = op_slice(ops_src_s, 2'd2); pb_s = 4'b0111; end
      ST_SETUP3:  begin t_s = op_slice(ops_src_s, 2'd3); pb_s = 4'b0111; end
      ST_HOLD3:   begin t_s = op_slice(ops_src_s, 2'd3); pb_s = 4'b1111; end
      ST_ROT:     begin t_s = op_slice(ops_src_s, 2'd3); pb_s = 4'b1111; rot_s = 1'b1; end
      ST_RELEASE: busy_s = 1'b1;
      default:    busy_s = 1'b0;
    endcase
    done_s = (state_r == ST_ROT) && (state_next_s == ST_RELEASE);
  end

  // State and panel-facing output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      t          <= {OP_W{1'b0}};
      pb1        <= 1'b0;
      pb2        <= 1'b0;
      pb3        <= 1'b0;
      pb4        <= 1'b0;
      rot_switch <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      t          <= t_s;
      pb1        <= pb_s[0];
      pb2        <= pb_s[1];
      pb3        <= pb_s[2];
      pb4        <= pb_s[3];
      rot_switch <= rot_s;
      busy       <= busy_s;
      done       <= done_s;
    end
  end

  // Operands and their reference sum are frozen when a request is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_r      <= {(NUM_OPS*OP_W){1'b0}};
      expected_r <= {SUM_W{1'b0}};
    end else if ((state_r == ST_IDLE) && start) begin
      ops_r      <= operands;
      expected_r <= nibble_sum(operands);
    end else begin
      ops_r      <= ops_r;
      expected_r <= expected_r;
    end
  end

  // Result capture on the edge that leaves ROT; held until the next capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result      <= {SUM_W{1'b0}};
      result_cout <= 1'b0;
      mismatch    <= 1'b0;
    end else if (done_s) begin
      result      <= sum_in;
      result_cout <= cout_in;
      mismatch    <= (sum_in != expected_r);
    end else begin
      result      <= result;
      result_cout <= result_cout;
      mismatch    <= mismatch;
    end
  end

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Scoreboard bench: two sequencers (default and 1/1 timing) each driving a behavioural adder.
module tb_adder_operand_sequencer;

  typedef struct {
    bit         inst;
    int         cyc;
    logic [5:0] res;
    logic       mm;
  } sb_item_t;

  sb_item_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic clk = 1'b0;
  logic rst_n, start0, start1, bad;
  logic [15:0] ops0, ops1;
  logic busy0, done0, cout0, mm0, rot0, pb1_0, pb2_0, pb3_0, pb4_0;
  logic busy1, done1, cout1, mm1, rot1, pb1_1, pb2_1, pb3_1, pb4_1;
  logic [5:0] res0, res1, sumin0, sumin1, sreg0, sreg1;
  logic [3:0] t0, t1;
  logic [3:0] cap0 [4];
  logic [3:0] cap1 [4];
  logic [3:0] pbprev0 = 4'd0;
  logic [3:0] pbprev1 = 4'd0;

  logic [3:0] tv [2];
  logic [3:0] pbv [2];
  logic       donev [2];
  logic       busyv [2];
  logic       rotv [2];
  logic [5:0] resv [2];
  logic       coutv [2];
  logic       mmv [2];
  logic [3:0] mon_pb [2];
  logic [3:0] mon_t [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adder_operand_sequencer dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .operands(ops0),
    .busy(busy0), .done(done0), .result(res0), .result_cout(cout0), .mismatch(mm0),
    .t(t0), .pb1(pb1_0), .pb2(pb2_0), .pb3(pb3_0), .pb4(pb4_0), .rot_switch(rot0),
    .sum_in(sumin0), .cout_in(1'b0)
  );

  adder_operand_sequencer #(.SETTLE_CYCLES(1), .RESULT_WAIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .operands(ops1),
    .busy(busy1), .done(done1), .result(res1), .result_cout(cout1), .mismatch(mm1),
    .t(t1), .pb1(pb1_1), .pb2(pb2_1), .pb3(pb3_1), .pb4(pb4_1), .rot_switch(rot1),
    .sum_in(sumin1), .cout_in(1'b0)
  );

  always_comb begin
    tv[0] = t0;  pbv[0] = {pb4_0, pb3_0, pb2_0, pb1_0};
    tv[1] = t1;  pbv[1] = {pb4_1, pb3_1, pb2_1, pb1_1};
    donev[0] = done0; busyv[0] = busy0; rotv[0] = rot0; resv[0] = res0; coutv[0] = cout0; mmv[0] = mm0;
    donev[1] = done1; busyv[1] = busy1; rotv[1] = rot1; resv[1] = res1; coutv[1] = cout1; mmv[1] = mm1;
  end

  // Behavioural adders: latch t on each PB rising edge, present the sum while ROT is high.
  always @({pb4_0, pb3_0, pb2_0, pb1_0}) begin
    for (int k = 0; k < 4; k++)
      if (pbv[0][k] && !pbprev0[k]) cap0[k] = t0;
    pbprev0 = {pb4_0, pb3_0, pb2_0, pb1_0};
  end
  always @({pb4_1, pb3_1, pb2_1, pb1_1}) begin
    for (int k = 0; k < 4; k++)
      if (pbv[1][k] && !pbprev1[k]) cap1[k] = t1;
    pbprev1 = {pb4_1, pb3_1, pb2_1, pb1_1};
  end
  always @(posedge rot0) sreg0 = 6'(cap0[0]) + 6'(cap0[1]) + 6'(cap0[2]) + 6'(cap0[3]);
  always @(posedge rot1) sreg1 = 6'(cap1[0]) + 6'(cap1[1]) + 6'(cap1[2]) + 6'(cap1[3]);
  assign sumin0 = rot0 ? (bad ? 6'd52 : sreg0) : 6'd0;
  assign sumin1 = rot1 ? sreg1 : 6'd0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [5:0] nsum(input logic [15:0] v);
    return 6'(v[3:0]) + 6'(v[7:4]) + 6'(v[11:8]) + 6'(v[15:12]);
  endfunction

  // Expected {busy, rot, pb[3:0], t[3:0]} in cycle c after the accepting edge.
  function automatic logic [9:0] exp_wave(input int c, input logic [15:0] ops, input int s, input int r);
    int p, k, n;
    logic [3:0] msk;
    if (c < 8*s) begin
      p = c / s; k = p / 2; n = k + (p % 2);
      msk = 4'((1 << n) - 1);
      return {1'b1, 1'b0, msk, ops[4*k +: 4]};
    end else if (c < 8*s + r) begin
      return {2'b11, 4'hF, ops[15:12]};
    end else if (c < 9*s + r) begin
      return {2'b10, 8'h00};
    end else begin
      return 10'd0;
    end
  endfunction

  // Monitor: PB ordering/t stability on every rising PB, and scoreboard pops on done.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if ((pbv[i] & ~mon_pb[i]) != 4'd0) begin
        check_eq("t_stable_at_pb", 32'(tv[i]), 32'(mon_t[i]));
        check_eq("pb_order", 32'(pbv[i]), 32'({mon_pb[i][2:0], 1'b1}));
      end
      mon_pb[i] <= pbv[i];
      mon_t[i]  <= tv[i];
      if (sb_q.size() > 0 && sb_q[0].inst == i[0] && cyc == sb_q[0].cyc) begin
        check_eq("done", 32'(donev[i]), 32'd1);
        check_eq("result", 32'(resv[i]), 32'(sb_q[0].res));
        check_eq("result_cout", 32'(coutv[i]), 32'd0);
        check_eq("mismatch", 32'(mmv[i]), 32'(sb_q[0].mm));
        void'(sb_q.pop_front());
      end else if (donev[i]) begin
        check_eq("spurious_done", 32'd1, 32'd0);
      end
    end
  end

  task automatic run_seq(input bit fast, input logic [15:0] ops, input int pulse_c, input bit hold);
    int s, r, tot, acc;
    logic [9:0] w;
    logic [5:0] esum;
    sb_item_t it;
    s = fast ? 1 : 2;
    r = fast ? 1 : 2;
    tot = 9*s + r;
    esum = nsum(ops);
    @(negedge clk);
    if (fast) begin ops1 = ops; start1 = 1'b1; end
    else      begin ops0 = ops; start0 = 1'b1; end
    acc = cyc + 1;
    it.inst = fast; it.cyc = acc + 8*s + r;
    it.res = (bad && !fast) ? 6'd52 : esum;
    it.mm = (it.res != esum);
    sb_q.push_back(it);
    for (int c = 0; c <= tot; c++) begin
      @(negedge clk);
      if (!hold) begin
        if (fast) start1 = (c == pulse_c); else start0 = (c == pulse_c);
        if (c == 2) begin
          if (fast) ops1 = ~ops; else ops0 = ~ops;
        end
      end
      w = exp_wave(c, ops, s, r);
      check_eq("t", 32'(tv[fast]), 32'(w[3:0]));
      check_eq("pb", 32'(pbv[fast]), 32'(w[7:4]));
      check_eq("rot_switch", 32'(rotv[fast]), 32'(w[8]));
      check_eq("busy", 32'(busyv[fast]), 32'(w[9]));
    end
    if (hold) begin
      it.cyc = acc + tot + 1 + 8*s + r;
      sb_q.push_back(it);
      @(negedge clk);
      check_eq("hold_restart_t", 32'(tv[fast]), 32'(ops[3:0]));
      check_eq("hold_restart_busy", 32'(busyv[fast]), 32'd1);
      if (fast) start1 = 1'b0; else start0 = 1'b0;
      repeat (tot) @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; bad = 1'b0;
    ops0 = 16'h0000; ops1 = 16'h0000;
    repeat (3) @(negedge clk);
    check_eq("reset_outs0", 32'({busy0, done0, rot0, pbv[0], t0, res0, cout0, mm0}), 32'd0);
    check_eq("reset_outs1", 32'({busy1, done1, rot1, pbv[1], t1, res1, cout1, mm1}), 32'd0);
    rst_n = 1'b1;

    run_seq(1'b0, 16'hBEDF, -1, 1'b0);
    run_seq(1'b0, 16'h0000, -1, 1'b0);
    run_seq(1'b0, 16'hFFFF, -1, 1'b0);
    bad = 1'b1;
    run_seq(1'b0, 16'hBEDF, -1, 1'b0);
    bad = 1'b0;
    run_seq(1'b0, 16'h1234, 5, 1'b0);
    run_seq(1'b0, 16'h8421, -1, 1'b1);

    // Asynchronous reset in the middle of HOLD2.
    @(negedge clk);
    ops0 = 16'h3C5A; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("pre_reset_pb", 32'(pbv[0]), 32'h7);
    #2 rst_n = 1'b0;
    sb_q.delete();
    #1;
    check_eq("async_rst_pb", 32'(pbv[0]), 32'd0);
    check_eq("async_rst_t", 32'(t0), 32'd0);
    check_eq("async_rst_busy", 32'(busy0), 32'd0);
    check_eq("async_rst_rot", 32'(rot0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_seq(1'b0, 16'h5A3C, -1, 1'b0);

    run_seq(1'b1, 16'hBEDF, -1, 1'b0);
    run_seq(1'b1, 16'h7F19, -1, 1'b0);

    repeat (3) @(negedge clk);
    check_eq("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
